// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded ownership. An owner keeps the grant while its
// request stays high, for at most MAX_HOLD consecutive cycles when others wait.
// All outputs are registered; there is no combinational path from req to grant.
module rr_hold_arbiter #(
  parameter int unsigned N        = 3,
  parameter int unsigned MAX_HOLD = 4,
  localparam int unsigned IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           preempt
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  logic           preempt_q, preempt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] last_q, last_d;

  logic [N-1:0]   arb_in;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [N-1:0]   win_onehot;

  // Round-robin search over arb_in starting just after the last winner.
  // In OWNED the owner is masked out, so a rotation can never re-pick it.
  always_comb begin
    int unsigned idx;
    arb_in     = (state_q == StOwned) ? (req & ~grant_q) : req;
    win_found  = 1'b0;
    win_idx    = '0;
    idx        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(last_q) + 1 + i) % N;
      if (!win_found && arb_in[idx]) begin
        win_found = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    preempt_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StOwned;
          grant_d = win_onehot;
          valid_d = 1'b1;
          id_d    = win_idx;
          last_d  = win_idx;
          cnt_d   = CW'(1);
        end
      end
      StOwned: begin
        if (|(req & grant_q)) begin
          if (cnt_q < CW'(MAX_HOLD)) begin
            cnt_d = cnt_q + CW'(1);
          end else if (win_found) begin
            grant_d   = win_onehot;
            id_d      = win_idx;
            last_d    = win_idx;
            cnt_d     = CW'(1);
            preempt_d = 1'b1;
          end else begin
            // Nobody else waiting: restart the hold window instead of yielding.
            cnt_d = CW'(1);
          end
        end else if (win_found) begin
          grant_d = win_onehot;
          id_d    = win_idx;
          last_d  = win_idx;
          cnt_d   = CW'(1);
        end else begin
          state_d = StIdle;
          grant_d = '0;
          valid_d = 1'b0;
          id_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous active-low reset returns pointer to N-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      cnt_q     <= '0;
      last_q    <= IDW'(N - 1);
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_id    = id_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Self-checking bench for rr_hold_arbiter (N=3, MAX_HOLD=4): directed vector
// table, hand-written reset sequences and random stimulus against a model.
module tb_rr_hold_arbiter;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .preempt    (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), cycles held, last winner.
  int m_owner;
  int m_held;
  int m_last;
  bit m_preempt;

  task automatic model_reset();
    m_owner   = -1;
    m_held    = 0;
    m_last    = N - 1;
    m_preempt = 0;
  endtask

  function automatic int pick(input logic [2:0] r, input int excl);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [2:0] r);
    int w;
    m_preempt = 0;
    if (m_owner < 0) begin
      w = pick(r, -1);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end
    end else if (r[m_owner]) begin
      if (m_held < MAX_HOLD) begin
        m_held++;
      end else begin
        w = pick(r, m_owner);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_held = 1; m_preempt = 1;
        end else begin
          m_held = 1;
        end
      end
    end else begin
      w = pick(r, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end else begin
        m_owner = -1; m_held = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply r before the next rising edge, advance the model, sample 1ns later.
  task automatic step(input logic [2:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] eg, input logic ep);
    logic [1:0] eid;
    eid = '0;
    for (int i = 0; i < N; i++) if (eg[i]) eid = 2'(i);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".preempt"}, 32'(preempt), 32'(ep));
    check({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
    check({tag, ".id"}, 32'(grant_id), 32'(eid));
  endtask

  task automatic check_model(input string tag);
    logic [2:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check_outputs(tag, eg, m_preempt);
  endtask

  typedef struct packed {
    logic [2:0] req;
    logic [2:0] grant;
    logic       preempt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [2:0] g, input logic p, input int n);
    vec_t v;
    v.req = r; v.grant = g; v.preempt = p;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    reset = 1'b0;
    req   = 3'b111;
    model_reset();

    // Reset held with all requests pending.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 3'b000, 1'b0);

    // Rotation with all requesting, then sole owner, single requester, handoff.
    add(3'b111, 3'b001, 1'b0, 4);
    add(3'b111, 3'b010, 1'b1, 1);
    add(3'b111, 3'b010, 1'b0, 3);
    add(3'b111, 3'b100, 1'b1, 1);
    add(3'b111, 3'b100, 1'b0, 3);
    add(3'b111, 3'b001, 1'b1, 1);
    add(3'b111, 3'b001, 1'b0, 1);
    add(3'b000, 3'b000, 1'b0, 1);
    add(3'b001, 3'b001, 1'b0, 10);
    add(3'b000, 3'b000, 1'b0, 1);
    add(3'b010, 3'b010, 1'b0, 2);
    add(3'b000, 3'b000, 1'b0, 2);
    add(3'b001, 3'b001, 1'b0, 1);
    add(3'b101, 3'b001, 1'b0, 1);
    add(3'b100, 3'b100, 1'b0, 1);
    add(3'b000, 3'b000, 1'b0, 1);
    add(3'b111, 3'b001, 1'b0, 1);

    reset = 1'b1;
    model_reset();
    foreach (vecs[i]) begin
      step(vecs[i].req);
      check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].preempt);
      check_model($sformatf("vec%0d.model", i));
    end

    // Owner 0 releases while 2 waits; then async reset in the middle of a cycle.
    step(3'b100);
    check_outputs("to_owner2", 3'b100, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("async_reset", 3'b000, 1'b0);
    req = 3'b110;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("held_reset", 3'b000, 1'b0);
    reset = 1'b1;
    model_reset();
    step(3'b110);
    check_outputs("post_reset", 3'b010, 1'b0);

    // Random traffic, biased toward sustained requests to exercise expiry.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : req;
      if ($urandom_range(0, 9) == 0) r = 3'b111;
      step(r);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
